mult_seq_ctrl: RTL and testbench

Sequencer for the bit-serial multiplier (`MULT_seq`, M-bit stationary operand × 1-bit serial stream). It accepts an N-bit serial operand and an M-bit stationary operand over a valid/ready handshake and loads the stationary operand by pulsing the multiplier's reset. It then streams the serial operand LSB-first, followed by zero-flush bits, deserializes the product stream, and returns the full (N+M)-bit product over a second valid/ready handshake. It sits between the operand source and the multiplier datapath and is the only agent driving that multiplier.

---
 rtl/mult_seq_ctrl_pkg.sv | 29 ++
 rtl/mult_seq_ctrl_deser.sv | 32 +++
 rtl/mult_seq_ctrl.sv | 108 ++++++++++
 tb/tb_mult_seq_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mult_seq_ctrl_pkg.sv
// Shared types and sizing helpers for the bit-serial multiplier sequencer.
package mult_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FEED = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r = r + 1;
    return r;
  endfunction

  // Serial bits plus zero-flush plus multiplier latency.
  function automatic int unsigned feed_len(input int unsigned n, input int unsigned m,
                                           input int unsigned lat);
    return n + m + lat;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n, input int unsigned m,
                                            input int unsigned lat);
    return clog2(feed_len(n, m, lat) + 1);
  endfunction

endpackage

// File: rtl/mult_seq_ctrl_deser.sv
// LSB-first shift-in register collecting the serial product stream.
module mult_seq_ctrl_deser #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         shift_en,
  input  logic         bit_in,
  output logic [W-1:0] data
);

  logic [W-1:0] data_q, data_d;

  // New bits enter at the MSB so the first captured bit ends up at bit 0.
  always_comb begin
    data_d = data_q;
    if (clr) begin
      data_d = '0;
    end else if (shift_en) begin
      data_d = {bit_in, data_q[W-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) data_q <= '0;
    else     data_q <= data_d;
  end

  assign data = data_q;

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequencer for the bit-serial multiplier: load, stream operand LSB-first, deserialize product.
// Optional MULT_SEQ_CTRL_ZERO_BYPASS_EN: zero operand goes straight to DONE with a zero product.
module mult_seq_ctrl
  import mult_seq_ctrl_pkg::*;
#(
  parameter int unsigned M   = 128,
  parameter int unsigned N   = 32,
  parameter int unsigned LAT = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_a,
  input  logic [M-1:0]   in_x,
  output logic           mult_rst,
  output logic           mult_a,
  output logic [M-1:0]   mult_x,
  input  logic           mult_o,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N+M-1:0] out_p,
  output logic           busy
);

  localparam int unsigned FEED_LEN = feed_len(N, M, LAT);
  localparam int unsigned CNT_W    = cnt_width(N, M, LAT);
  localparam int unsigned P_W      = N + M;

  state_e           state_q, state_d;
  logic [N-1:0]     a_q, a_d;
  logic [M-1:0]     x_q, x_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             deser_clr;
  logic             deser_shift;

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    x_d         = x_q;
    cnt_d       = cnt_q;
    deser_clr   = 1'b0;
    deser_shift = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d       = in_a;
          x_d       = in_x;
          cnt_d     = '0;
          deser_clr = 1'b1;
          state_d   = LOAD;
`ifdef MULT_SEQ_CTRL_ZERO_BYPASS_EN
          if ((in_a == '0) || (in_x == '0)) state_d = DONE;
`endif
        end
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = FEED;
      end
      FEED: begin
        // a_q drains toward bit 0; once empty it supplies the zero-flush bits.
        a_d   = a_q >> 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q >= CNT_W'(LAT)) deser_shift = 1'b1;
        if (cnt_q == CNT_W'(FEED_LEN - 1)) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      x_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      x_q     <= x_d;
      cnt_q   <= cnt_d;
    end
  end

  mult_seq_ctrl_deser #(
    .W (P_W)
  ) u_deser (
    .clk      (clk),
    .rst      (rst),
    .clr      (deser_clr),
    .shift_en (deser_shift),
    .bit_in   (mult_o),
    .data     (out_p)
  );

  // Multiplier is held in reset alongside the controller.
  assign mult_rst  = rst | (state_q == LOAD);
  assign mult_a    = ~rst & (state_q == FEED) & a_q[0];
  assign mult_x    = x_q;
  assign in_ready  = ~rst & (state_q == IDLE);
  assign out_valid = ~rst & (state_q == DONE);
  assign busy      = ~rst & (state_q != IDLE);

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench for mult_seq_ctrl with a behavioural 4-bit bit-serial multiplier (LAT=1).
module tb_mult_seq_ctrl;

  localparam int unsigned M = 4;
  localparam int unsigned N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_a;
  logic [M-1:0] in_x;
  logic         mult_rst;
  logic         mult_a;
  logic [M-1:0] mult_x;
  logic         mult_o;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   out_p;
  logic         busy;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mult_seq_ctrl #(.M(M), .N(N), .LAT(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_x      (in_x),
    .mult_rst  (mult_rst),
    .mult_a    (mult_a),
    .mult_x    (mult_x),
    .mult_o    (mult_o),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .busy      (busy)
  );

  // Serial multiplier model: carry accumulator, one registered product bit per cycle.
  logic [4:0] mc;
  logic [5:0] ms;
  assign ms = {1'b0, mc} + (mult_a ? {2'b00, mult_x} : 6'd0);
  always @(posedge clk) begin
    if (mult_rst) begin
      mc     <= '0;
      mult_o <= 1'b0;
    end else begin
      mc     <= ms[5:1];
      mult_o <= ms[0];
    end
  end

  // Issue one operand pair from IDLE, wait for the product, then complete the handshake.
  task automatic run_op(input logic [3:0] a, input logic [3:0] x, output int lat,
                        output logic [7:0] p, output bit saw_rst, output bit to);
    int k;
    in_a = a; in_x = x; in_valid = 1'b1;
    saw_rst = 1'b0; to = 1'b1; lat = 0; p = '0; k = 0;
    while (to && k < 40) begin
      @(posedge clk); #1;
      k = k + 1;
      in_valid = 1'b0;
      if (mult_rst) saw_rst = 1'b1;
      if (out_valid) begin
        lat = k; p = out_p; to = 1'b0;
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_x = '0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got=%b exp=0", in_ready); else passed++;
    total++; if (mult_rst !== 1'b1) $display("FAIL reset_mult_rst got=%b exp=1", mult_rst); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
    total++; if (mult_a !== 1'b0) $display("FAIL reset_mult_a got=%b exp=0", mult_a); else passed++;
    total++; if (out_p !== 8'h00) $display("FAIL reset_out_p got=%h exp=00", out_p); else passed++;
    rst = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_release_in_ready got=%b exp=1", in_ready); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int lat; logic [7:0] p; bit sr, to;
    run_op(4'hB, 4'hD, lat, p, sr, to);
    total++; if (to) $display("FAIL basic_timeout no out_valid within 40 cycles"); else passed++;
    total++; if (lat != 11) $display("FAIL basic_latency got=%0d exp=11", lat); else passed++;
    total++; if (p !== 8'h8F) $display("FAIL basic_product got=%h exp=8f", p); else passed++;
    total++; if (sr !== 1'b1) $display("FAIL basic_mult_rst_pulse got=%b exp=1", sr); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL basic_ready_after got=%b exp=1", in_ready); else passed++;
  endtask

  task automatic test_max();
    int lat; logic [7:0] p; bit sr, to;
    run_op(4'hF, 4'hF, lat, p, sr, to);
    total++; if (to || lat != 11) $display("FAIL max_latency got=%0d exp=11", lat); else passed++;
    total++; if (p !== 8'hE1) $display("FAIL max_product got=%h exp=e1", p); else passed++;
  endtask

  task automatic test_backpressure();
    int k;
    in_a = 4'h6; in_x = 4'h7; in_valid = 1'b1; k = 0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++; if (busy !== 1'b1) $display("FAIL bp_busy_load got=%b exp=1", busy); else passed++;
    while (!out_valid && k < 40) begin
      @(posedge clk); #1;
      k = k + 1;
    end
    total++; if (out_valid !== 1'b1) $display("FAIL bp_timeout out_valid=%b exp=1", out_valid); else passed++;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b1 || out_p !== 8'h2A || in_ready !== 1'b0)
        $display("FAIL bp_hold_%0d valid=%b p=%h ready=%b exp valid=1 p=2a ready=0",
                 i, out_valid, out_p, in_ready);
      else passed++;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++; if (in_ready !== 1'b1) $display("FAIL bp_release_ready got=%b exp=1", in_ready); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL bp_release_valid got=%b exp=0", out_valid); else passed++;
  endtask

  task automatic test_back_to_back();
    int cyc, n_out, t0, t1, guard;
    logic [7:0] p0, p1;
    cyc = 0; n_out = 0; t0 = 0; t1 = 0; p0 = '0; p1 = '0; guard = 0;
    out_ready = 1'b1;
    in_a = 4'h3; in_x = 4'h5; in_valid = 1'b1;
    @(posedge clk); #1;
    cyc = 1;
    in_a = 4'h7; in_x = 4'h9;
    while (n_out < 2 && guard < 60) begin
      if (out_valid) begin
        if (n_out == 0) begin t0 = cyc; p0 = out_p; end
        else begin t1 = cyc; p1 = out_p; in_valid = 1'b0; end
        n_out = n_out + 1;
      end
      if (n_out < 2) begin
        @(posedge clk); #1;
        cyc = cyc + 1;
        guard = guard + 1;
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++; if (n_out != 2) $display("FAIL b2b_count got=%0d exp=2", n_out); else passed++;
    total++; if (t0 != 11) $display("FAIL b2b_first_latency got=%0d exp=11", t0); else passed++;
    total++; if (p0 !== 8'h0F) $display("FAIL b2b_first_product got=%h exp=0f", p0); else passed++;
    total++; if (p1 !== 8'h3F) $display("FAIL b2b_second_product got=%h exp=3f", p1); else passed++;
    total++; if (t1 - t0 != 12) $display("FAIL b2b_spacing got=%0d exp=12", t1 - t0); else passed++;
  endtask

  task automatic test_reset_mid_feed();
    int lat; logic [7:0] p; bit sr, to;
    in_a = 4'hB; in_x = 4'hD; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    total++; if (mult_rst !== 1'b1) $display("FAIL midrst_mult_rst got=%b exp=1", mult_rst); else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) $display("FAIL midrst_out_valid got=%b exp=0", out_valid); else passed++;
    total++; if (busy !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL midrst_idle busy=%b ready=%b exp busy=0 ready=1", busy, in_ready); else passed++;
    run_op(4'h2, 4'h6, lat, p, sr, to);
    total++; if (to || lat != 11) $display("FAIL midrst_next_latency got=%0d exp=11", lat); else passed++;
    total++; if (p !== 8'h0C) $display("FAIL midrst_next_product got=%h exp=0c", p); else passed++;
  endtask

  task automatic test_zero();
    int lat; logic [7:0] p; bit sr, to;
    run_op(4'h0, 4'h9, lat, p, sr, to);
    total++; if (p !== 8'h00) $display("FAIL zero_product got=%h exp=00", p); else passed++;
`ifdef MULT_SEQ_CTRL_ZERO_BYPASS_EN
    total++; if (to || lat != 1) $display("FAIL zero_latency got=%0d exp=1", lat); else passed++;
    total++; if (sr !== 1'b0) $display("FAIL zero_mult_rst_pulse got=%b exp=0", sr); else passed++;
`else
    total++; if (to || lat != 11) $display("FAIL zero_latency got=%0d exp=11", lat); else passed++;
    total++; if (sr !== 1'b1) $display("FAIL zero_mult_rst_pulse got=%b exp=1", sr); else passed++;
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_feed();
    test_zero();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
